pc_sequencer: RTL and testbench

- Program-counter stage sitting directly downstream of the PC target-address selector.
- Owns the architectural PC, the latched branch/jump target, and MIPS branch-delay-slot sequencing.
- Drives the fetch address, PC+4 (back to the selector and to the link-register path), and the CPU `active` flag.
- A redirect commits after exactly one delay-slot instruction; a jump to HALT_ADDR stops the CPU.

---
 rtl/pc_sequencer.sv | 77 +++++++
 tb/tb_pc_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter stage: owns the architectural PC, the latched branch/jump target
// and MIPS branch-delay-slot sequencing, and halts the CPU on a jump to HALT_ADDR.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] tgt_addr_0,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        active,
  output logic        in_delay_slot,
  output logic        addr_err
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_holder;
  logic        r_addr_err;
  logic        w_commit;
  logic [31:0] w_pc_plus4;

  // A stalled cycle swallows the commit pulse; control must re-present it.
  assign w_commit   = advance & ~stall;
  assign w_pc_plus4 = r_pc + 32'd4;

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values of r_pc, r_holder and r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_VECTOR;
      r_holder   <= 32'd0;
      r_addr_err <= 1'b0;
    end else if (w_commit) begin
      case (r_state)
        ST_RUN: begin
          r_pc <= w_pc_plus4;
          if (redirect) begin
            r_holder <= tgt_addr_0;
            r_state  <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          // A branch sitting in the delay slot is dropped; the first target wins.
          r_pc <= r_holder;
          if (r_holder == HALT_ADDR) begin
            r_state <= ST_HALTED;
          end else if (r_holder[1:0] != 2'b00) begin
            r_addr_err <= 1'b1;
            r_state    <= ST_HALTED;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

  assign pc_out        = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign active        = (r_state != ST_HALTED);
  assign in_delay_slot = (r_state == ST_DELAY);
  assign addr_err      = r_addr_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven vectors through a scoreboard
// queue, plus hand-written halt, misaligned-target and async-reset sequences.
module tb_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        advance;
  logic        redirect;
  logic [31:0] tgt_addr_0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        active;
  logic        in_delay_slot;
  logic        addr_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        stall;
    logic        advance;
    logic        redirect;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_active;
    logic        exp_ds;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  pc_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .advance       (advance),
    .redirect      (redirect),
    .tgt_addr_0    (tgt_addr_0),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .active        (active),
    .in_delay_slot (in_delay_slot),
    .addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic adv, input logic rd,
                              input logic [31:0] tgt, input logic [31:0] pc,
                              input logic act, input logic ds, input logic err);
    vec_t v;
    v.stall = st; v.advance = adv; v.redirect = rd; v.tgt = tgt;
    v.exp_pc = pc; v.exp_active = act; v.exp_ds = ds; v.exp_err = err;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [31:0] pc, input logic act,
                               input logic ds, input logic err);
    check({tag, ".pc_out"}, pc_out, pc);
    check({tag, ".pc_plus4"}, pc_plus4, pc + 32'd4);
    check({tag, ".active"}, {31'd0, active}, {31'd0, act});
    check({tag, ".in_delay_slot"}, {31'd0, in_delay_slot}, {31'd0, ds});
    check({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, err});
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    stall = v.stall; advance = v.advance; redirect = v.redirect; tgt_addr_0 = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e.exp_pc, e.exp_active, e.exp_ds, e.exp_err);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; stall = 1'b0; advance = 1'b0; redirect = 1'b0; tgt_addr_0 = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; advance = 1'b0; redirect = 1'b0; tgt_addr_0 = 32'd0;
    #12;
    check_outputs("reset", 32'hBFC00000, 1'b1, 1'b0, 1'b0);
    do_reset();

    // Main table: sequential fetch, redirect, stall/no-advance holds, wrap,
    // branch in delay slot, back-to-back redirects, halt and post-halt ignores.
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'hBFC00004, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'hBFC00008, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'hBFC0000C, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'hBFC00010, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'hBFC00100, 32'hBFC00014, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'hBFC00100, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        32'hBFC00100, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h00000044, 32'hBFC00100, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'hBFC00104, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFF8, 32'hBFC00108, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'hFFFFFFF8, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'hFFFFFFFC, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h00000000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h00000004, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h00000010, 32'h00000008, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h00000080, 32'h00000010, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h00000200, 32'h00000014, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        32'h00000014, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h00000200, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 0, 32'h0,      32'h00000200, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h00000000, 32'h00000204, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h00000000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h00000000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h00000040, 32'h00000000, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Halt from the reset region: redirect to 0 at pc 0xBFC00020.
    do_reset();
    for (int i = 1; i <= 8; i++)
      apply($sformatf("halt_seq%0d", i),
            mk(0, 1, 0, 32'h0, 32'hBFC00000 + 32'(i * 4), 1, 0, 0));
    apply("halt_br",   mk(0, 1, 1, 32'h00000000, 32'hBFC00024, 1, 1, 0));
    apply("halt_ds",   mk(0, 1, 0, 32'h0,        32'h00000000, 0, 0, 0));
    apply("halt_hold", mk(0, 1, 0, 32'h0,        32'h00000000, 0, 0, 0));

    // Misaligned target: committed, then sticky addr_err and halt.
    do_reset();
    apply("mis_br",   mk(0, 1, 1, 32'hBFC00102, 32'hBFC00004, 1, 1, 0));
    apply("mis_ds",   mk(0, 1, 0, 32'h0,        32'hBFC00102, 0, 0, 1));
    apply("mis_hold", mk(0, 1, 0, 32'h0,        32'hBFC00102, 0, 0, 1));

    // Asynchronous reset between edges clears addr_err while halted.
    @(negedge clk);
    advance = 1'b0; redirect = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_outputs("areset_halted", 32'hBFC00000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset while in the delay slot.
    apply("ards_br", mk(0, 1, 1, 32'h00000100, 32'hBFC00004, 1, 1, 0));
    @(negedge clk);
    advance = 1'b0; redirect = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_outputs("areset_delay", 32'hBFC00000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    apply("post_reset", mk(0, 1, 0, 32'h0, 32'hBFC00004, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
